// File: rtl/pulse_gen.sv
// Retriggerable fixed-width pulse generator. Each pulse is followed by a minimum
// low gap, and at most one request is queued while a pulse or gap is in progress.
module pulse_gen #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  output logic       out,
  output logic       busy,
  output logic       pending,
  output logic       dropped,
  output logic [1:0] dbg_state
);

  if (HIGH_CYCLES < 1 || HIGH_CYCLES > 255) begin : g_bad_high
    $error("pulse_gen: HIGH_CYCLES must be in 1..255");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("pulse_gen: GAP_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // The counter holds the remaining cycles minus one, so zero marks the last cycle.
  localparam logic [7:0] HIGH_LOAD = 8'(HIGH_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       out_q, out_d;
  logic       pending_q, pending_d;
  logic       dropped_q, dropped_d;
  logic       gap_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      out_q     <= 1'b0;
      pending_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      pending_q <= pending_d;
      dropped_q <= dropped_d;
    end
  end

  assign gap_end = (state_q == ST_GAP) && (cnt_q == 8'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      ST_HIGH: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == 8'd0) begin
          // A request arriving on the final gap edge is as good as a queued one.
          if (pending_q || trig) begin
            state_d = ST_HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    dropped_d = 1'b0;
    out_d     = (state_d == ST_HIGH);
    if (state_q != ST_IDLE) begin
      if (gap_end) begin
        // The queued request launches now; a fresh trig alongside it is lost.
        pending_d = 1'b0;
        dropped_d = trig && pending_q;
      end else if (trig) begin
        if (pending_q) dropped_d = 1'b1;
        else           pending_d = 1'b1;
      end
    end
  end

  assign out       = out_q;
  assign pending   = pending_q;
  assign dropped   = dropped_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: default 4/2 instance plus a 1/1 instance.
// Bit c of each recorded vector is the output value during cycle c (after edge c-1).
module tb_pulse_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig1 = 1'b0;
  logic       trig2 = 1'b0;
  logic       out1, busy1, pending1, dropped1;
  logic       out2, busy2, pending2, dropped2;
  logic [1:0] dbg1, dbg2;

  logic [63:0] exp_q[$];
  logic [63:0] out_rec, busy_rec, pend_rec, drop_rec;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulse_gen #(.HIGH_CYCLES(4), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .trig(trig1), .out(out1), .busy(busy1),
    .pending(pending1), .dropped(dropped1), .dbg_state(dbg1)
  );

  pulse_gen #(.HIGH_CYCLES(1), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .trig(trig2), .out(out2), .busy(busy2),
    .pending(pending2), .dropped(dropped2), .dbg_state(dbg2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: expectations are queued first, then consumed in order.
  task automatic check_next(input string tag, input logic [63:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s no expected value queued", tag);
    end else begin
      check_eq(tag, got, exp_q.pop_front());
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic int max_run(input logic [63:0] v);
    int run;
    int best;
    run = 0;
    best = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) run++;
      else run = 0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    trig1 = 1'b0;
    trig2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives trig from the edge mask and records outputs of the selected instance.
  task automatic run(input bit sel, input logic [63:0] tvec, input int n);
    out_rec  = '0;
    busy_rec = '0;
    pend_rec = '0;
    drop_rec = '0;
    for (int e = 0; e < n; e++) begin
      @(negedge clk);
      if (sel) trig2 = tvec[e];
      else     trig1 = tvec[e];
      @(posedge clk);
      #1;
      out_rec[e+1]  = sel ? out2     : out1;
      busy_rec[e+1] = sel ? busy2    : busy1;
      pend_rec[e+1] = sel ? pending2 : pending1;
      drop_rec[e+1] = sel ? dropped2 : dropped1;
    end
    @(negedge clk);
    trig1 = 1'b0;
    trig2 = 1'b0;
  endtask

  initial begin
    logic [63:0] v;
    logic [63:0] tv;

    // Reset state while rst is held
    #12;
    check_eq("rst_out", {63'd0, out1}, 64'd0);
    check_eq("rst_busy", {63'd0, busy1}, 64'd0);
    check_eq("rst_pending", {63'd0, pending1}, 64'd0);
    check_eq("rst_dropped", {63'd0, dropped1}, 64'd0);
    check_eq("rst_state", {62'd0, dbg1}, 64'd0);

    // Single trig at edge 10
    do_reset();
    tv = '0; tv[10] = 1'b1;
    exp_q.push_back(rng(11, 14));
    exp_q.push_back(rng(11, 16));
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    run(1'b0, tv, 30);
    check_next("single_out", out_rec);
    check_next("single_busy", busy_rec);
    check_next("single_pending", pend_rec);
    check_next("single_dropped", drop_rec);

    // Trigs at 10 and 12: second request queued behind the first
    do_reset();
    tv = '0; tv[10] = 1'b1; tv[12] = 1'b1;
    exp_q.push_back(rng(11, 14) | rng(17, 20));
    exp_q.push_back(rng(13, 16));
    exp_q.push_back(rng(11, 22));
    exp_q.push_back(64'd0);
    run(1'b0, tv, 30);
    check_next("queue_out", out_rec);
    check_next("queue_pending", pend_rec);
    check_next("queue_busy", busy_rec);
    check_next("queue_dropped", drop_rec);

    // Trigs at 10, 12, 13: third is dropped
    do_reset();
    tv = '0; tv[10] = 1'b1; tv[12] = 1'b1; tv[13] = 1'b1;
    exp_q.push_back(rng(14, 14));
    exp_q.push_back(rng(11, 14) | rng(17, 20));
    exp_q.push_back(rng(13, 16));
    run(1'b0, tv, 30);
    check_next("drop_dropped", drop_rec);
    check_next("drop_out", out_rec);
    check_next("drop_pending", pend_rec);

    // Trig on the final gap edge with nothing queued goes straight to HIGH
    do_reset();
    tv = '0; tv[10] = 1'b1; tv[16] = 1'b1;
    exp_q.push_back(rng(11, 14) | rng(17, 20));
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    exp_q.push_back(rng(11, 22));
    run(1'b0, tv, 30);
    check_next("lastgap_out", out_rec);
    check_next("lastgap_pending", pend_rec);
    check_next("lastgap_dropped", drop_rec);
    check_next("lastgap_busy", busy_rec);

    // Trig on the final gap edge with one queued: queued one runs, new one dropped
    do_reset();
    tv = '0; tv[10] = 1'b1; tv[12] = 1'b1; tv[16] = 1'b1;
    exp_q.push_back(rng(11, 14) | rng(17, 20));
    exp_q.push_back(rng(13, 16));
    exp_q.push_back(rng(17, 17));
    exp_q.push_back(rng(11, 22));
    run(1'b0, tv, 30);
    check_next("lastgap_q_out", out_rec);
    check_next("lastgap_q_pending", pend_rec);
    check_next("lastgap_q_dropped", drop_rec);
    check_next("lastgap_q_busy", busy_rec);

    // Trig held for edges 10..39: periodic 4 high / 2 low train
    do_reset();
    tv = rng(10, 39);
    v = '0;
    for (int p = 11; p <= 41; p += 6) v |= rng(p, p + 3);
    exp_q.push_back(v);
    exp_q.push_back(rng(11, 46));
    run(1'b0, tv, 55);
    check_next("train_out", out_rec);
    check_next("train_busy", busy_rec);
    check_eq("train_max_run", 64'(max_run(out_rec)), 64'd4);

    // Async reset mid-pulse with a request queued
    do_reset();
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      trig1 = (e == 10 || e == 11);
      @(posedge clk);
      #1;
    end
    check_eq("prerst_out", {63'd0, out1}, 64'd1);
    check_eq("prerst_pending", {63'd0, pending1}, 64'd1);
    #2;
    rst   = 1'b1;
    trig1 = 1'b0;
    #1;
    check_eq("midrst_out", {63'd0, out1}, 64'd0);
    check_eq("midrst_pending", {63'd0, pending1}, 64'd0);
    check_eq("midrst_busy", {63'd0, busy1}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tv = '0; tv[5] = 1'b1;
    exp_q.push_back(rng(6, 9));
    exp_q.push_back(rng(6, 11));
    run(1'b0, tv, 20);
    check_next("postrst_out", out_rec);
    check_next("postrst_busy", busy_rec);

    // HIGH_CYCLES=1, GAP_CYCLES=1 with trig held: out toggles every cycle
    do_reset();
    tv = rng(10, 29);
    v = '0;
    for (int c = 11; c <= 31; c += 2) v[c] = 1'b1;
    exp_q.push_back(v);
    exp_q.push_back(rng(11, 32));
    run(1'b1, tv, 40);
    check_next("toggle_out", out_rec);
    check_next("toggle_busy", busy_rec);
    check_eq("toggle_max_run", 64'(max_run(out_rec)), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
